// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and defaults for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    ARB   = 1'b0,
    STALL = 1'b1
  } arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Client request channel and tagged read-response channel of the arbiter.
interface regfile_port_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_a;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_b;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data1;
  logic [DATA_W-1:0]         rsp_data2;

  modport master (
    output req_valid, req_we, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
  );

  modport slave (
    input  req_valid, req_we, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               valid_o
);
  logic [ID_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        id_o         = idx;
        grant_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one 2R/1W register file among NUM_REQ clients.
// Optional REGFILE_ARB_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  regfile_port_arbiter_if.slave port,
  output logic [ADDR_W-1:0]   rf_sel1,
  output logic [ADDR_W-1:0]   rf_sel2,
  output logic [ADDR_W-1:0]   rf_sel_write,
  output logic [DATA_W-1:0]   rf_data_write,
  output logic                rf_read_sel,
  output logic                rf_write_sel,
  input  logic [DATA_W-1:0]   rf_data_read1,
  input  logic [DATA_W-1:0]   rf_data_read2
);
  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
  logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;

  logic [ADDR_W-1:0] sel1_q, sel2_q, selw_q;
  logic [DATA_W-1:0] wdata_q;

  logic [NUM_REQ-1:0] eligible, grant;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               read_slot_free;
  logic [ADDR_W-1:0]  addr_a_g, addr_b_g;
  logic [DATA_W-1:0]  wdata_g;
  logic               we_g, do_read, do_write;

  // Writes never touch the response slot, so only reads wait for it.
  always_comb begin
    read_slot_free = (state_q == ARB) ? (!rsp_valid_q || port.rsp_ready) : port.rsp_ready;
    eligible = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      eligible[k] = port.req_valid[k] && !reset && (port.req_we[k] || read_slot_free);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .id_o    (gnt_id),
    .valid_o (gnt_valid)
  );

  always_comb begin
    addr_a_g = port.req_addr_a[32'(gnt_id)*ADDR_W +: ADDR_W];
    addr_b_g = port.req_addr_b[32'(gnt_id)*ADDR_W +: ADDR_W];
    wdata_g  = port.req_wdata[32'(gnt_id)*DATA_W +: DATA_W];
    we_g     = port.req_we[gnt_id];
    do_read  = gnt_valid && !we_g;
`ifdef REGFILE_ARB_ZERO_REG_EN
    do_write = gnt_valid && we_g && (addr_a_g != '0);
`else
    do_write = gnt_valid && we_g;
`endif
  end

  assign port.req_ready = grant;
  assign rf_sel1        = gnt_valid ? addr_a_g : sel1_q;
  assign rf_sel2        = gnt_valid ? addr_b_g : sel2_q;
  assign rf_sel_write   = gnt_valid ? addr_a_g : selw_q;
  assign rf_data_write  = gnt_valid ? wdata_g  : wdata_q;
  assign rf_read_sel    = do_read;
  assign rf_write_sel   = do_write;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data1_d = rsp_data1_q;
    rsp_data2_d = rsp_data2_q;

    if (gnt_valid) begin
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    if (do_read) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
`ifdef REGFILE_ARB_ZERO_REG_EN
      rsp_data1_d = (addr_a_g == '0) ? '0 : rf_data_read1;
      rsp_data2_d = (addr_b_g == '0) ? '0 : rf_data_read2;
`else
      rsp_data1_d = rf_data_read1;
      rsp_data2_d = rf_data_read2;
`endif
    end else if (port.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      ARB:     if (rsp_valid_q && !port.rsp_ready) state_d = STALL;
      STALL:   if (rsp_valid_q && port.rsp_ready)  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_data2_q <= rsp_data2_d;
    end
  end

  // Register-file lines keep their last driven value between grants.
  always_ff @(posedge clk) begin
    if (gnt_valid) begin
      sel1_q  <= addr_a_g;
      sel2_q  <= addr_b_g;
      selw_q  <= addr_a_g;
      wdata_q <= wdata_g;
    end
  end

  assign port.rsp_valid = rsp_valid_q;
  assign port.rsp_id    = rsp_id_q;
  assign port.rsp_data1 = rsp_data1_q;
  assign port.rsp_data2 = rsp_data2_q;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed plus randomized bench for regfile_port_arbiter against a behavioural model.
module tb_regfile_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef REGFILE_ARB_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  logic [AW-1:0] rf_sel1, rf_sel2, rf_sel_write;
  logic [DW-1:0] rf_data_write, rf_data_read1, rf_data_read2;
  logic          rf_read_sel, rf_write_sel;

  regfile_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .port          (bus),
    .rf_sel1       (rf_sel1),
    .rf_sel2       (rf_sel2),
    .rf_sel_write  (rf_sel_write),
    .rf_data_write (rf_data_write),
    .rf_read_sel   (rf_read_sel),
    .rf_write_sel  (rf_write_sel),
    .rf_data_read1 (rf_data_read1),
    .rf_data_read2 (rf_data_read2)
  );

  // Register file attached to the DUT, plus a bench-side preload port.
  logic [DW-1:0] rf_mem [32];
  logic          ld_en = 1'b0;
  logic [4:0]    ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) rf_mem[ld_addr] <= ld_data;
    else if (rf_write_sel) rf_mem[rf_sel_write] <= rf_data_write;
  end
  assign rf_data_read1 = rf_mem[rf_sel1];
  assign rf_data_read2 = rf_mem[rf_sel2];

  // Client stimulus
  bit [N-1:0]  c_valid, c_we;
  bit [AW-1:0] c_a [N];
  bit [AW-1:0] c_b [N];
  bit [DW-1:0] c_wd [N];
  bit          c_rsp_ready;

  // Reference model
  int            m_ptr;
  bit            m_valid;
  int            m_id;
  logic [DW-1:0] m_d1, m_d2;
  logic [DW-1:0] ref_mem [32];
  bit            sel_known;
  logic [AW-1:0] m_s1, m_s2, m_sw;
  logic [DW-1:0] m_dw;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (c_valid[i] && !reset && (c_we[i] || !m_valid || c_rsp_ready)) return i;
    end
    return -1;
  endfunction

  task automatic step();
    int g;
    bit wr_en, rd_en;
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = c_valid[i];
      bus.req_we[i]    = c_we[i];
      bus.req_addr_a[i*AW +: AW] = c_a[i];
      bus.req_addr_b[i*AW +: AW] = c_b[i];
      bus.req_wdata[i*DW +: DW]  = c_wd[i];
    end
    bus.rsp_ready = c_rsp_ready;
    g = ref_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    wr_en = (g >= 0) && c_we[g] && !(ZERO_EN && c_a[g] == '0);
    rd_en = (g >= 0) && !c_we[g];
    #4;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("rf_write_sel", 64'(rf_write_sel), 64'(wr_en));
    chk("rf_read_sel", 64'(rf_read_sel), 64'(rd_en));
    if (g >= 0) begin
      sel_known = 1'b1;
      m_s1 = c_a[g]; m_s2 = c_b[g]; m_sw = c_a[g]; m_dw = c_wd[g];
    end
    if (sel_known) begin
      chk("rf_sel1", 64'(rf_sel1), 64'(m_s1));
      chk("rf_sel2", 64'(rf_sel2), 64'(m_s2));
      chk("rf_sel_write", 64'(rf_sel_write), 64'(m_sw));
      chk("rf_data_write", 64'(rf_data_write), 64'(m_dw));
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
    chk("rsp_data1", 64'(bus.rsp_data1), 64'(m_d1));
    chk("rsp_data2", 64'(bus.rsp_data2), 64'(m_d2));
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_valid = 1'b0; m_id = 0; m_d1 = '0; m_d2 = '0;
    end else if (g >= 0) begin
      if (rd_en) begin
        m_valid = 1'b1;
        m_id    = g;
        m_d1    = (ZERO_EN && c_a[g] == '0) ? '0 : ref_mem[c_a[g]];
        m_d2    = (ZERO_EN && c_b[g] == '0) ? '0 : ref_mem[c_b[g]];
      end else begin
        if (wr_en) ref_mem[c_a[g]] = c_wd[g];
        if (c_rsp_ready) m_valid = 1'b0;
      end
      m_ptr = (g + 1) % N;
    end else if (c_rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    if (g >= 0) c_valid[g] = 1'b0;
  endtask

  task automatic set_req(input int i, input bit we, input int a, input int b, input logic [DW-1:0] wd);
    c_valid[i] = 1'b1; c_we[i] = we;
    c_a[i] = AW'(a); c_b[i] = AW'(b); c_wd[i] = wd;
  endtask

  initial begin
    int order [5];
    logic [DW-1:0] wd;
    order = '{0, 1, 2, 3, 0};
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_d1 = '0; m_d2 = '0; sel_known = 1'b0;
    c_valid = '0; c_we = '0; c_rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin c_a[i] = '0; c_b[i] = '0; c_wd[i] = '0; end
    reset = 1'b1;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr_a = '0; bus.req_addr_b = '0;
    bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Preload under reset with every client requesting; nothing may be granted.
    for (int i = 0; i < 32; i++) begin
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = $urandom; ref_mem[i] = ld_data;
      for (int c = 0; c < N; c++) set_req(c, c[0], c, c + 1, 32'(c));
      step();
    end
    ld_en = 1'b0;
    c_valid = '0;
    reset = 1'b0;

    // Write then read-after-write from client 0.
    set_req(0, 1'b1, 3, 0, 32'd9);
    step();
    set_req(0, 1'b0, 3, 0, '0);
    step();
    chk("raw_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("raw_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("raw_rsp_data1", 64'(bus.rsp_data1), 64'd9);

    // Round-robin order from a fresh reset with all clients reading.
    reset = 1'b1; step(); reset = 1'b0;
    c_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < N; c++) if (!c_valid[c]) set_req(c, 1'b0, c + 4, c + 8, '0);
      step();
      chk("rr_rsp_id", 64'(bus.rsp_id), 64'(order[k]));
    end
    c_valid = '0;

    // Client 1 response held for three cycles while 2 and 3 wait.
    set_req(1, 1'b0, 5, 6, '0);
    step();
    c_rsp_ready = 1'b0;
    set_req(2, 1'b0, 3, 9, '0);
    set_req(3, 1'b0, 10, 11, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_rsp_id", 64'(bus.rsp_id), 64'd1);
      chk("stall_rsp_data1", 64'(bus.rsp_data1), 64'(ref_mem[5]));
    end
    c_rsp_ready = 1'b1;
    step();
    chk("release_rsp_id", 64'(bus.rsp_id), 64'd2);

    // Write from client 2 goes through while the response slot is held.
    c_rsp_ready = 1'b0;
    wd = $urandom;
    set_req(2, 1'b1, 7, 0, wd);
    step();
    chk("stall_write_commit", 64'(rf_mem[7]), 64'(wd));
    chk("stall_write_rsp_id", 64'(bus.rsp_id), 64'd2);
    c_rsp_ready = 1'b1;
    step();

    // Reset while a response is pending and requests are waiting.
    set_req(0, 1'b0, 1, 2, '0);
    step();
    c_rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, c + 12, c + 20, '0);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    c_rsp_ready = 1'b1;
    step();
    chk("post_reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    c_valid = '0;
    step();

    // Register 0 handling.
    set_req(1, 1'b1, 0, 0, 32'h0000_FFFF);
    step();
    set_req(1, 1'b0, 0, 0, '0);
    step();
    chk("zero_rsp_data1", 64'(bus.rsp_data1), ZERO_EN ? 64'd0 : 64'h0000_FFFF);
    chk("zero_rsp_data2", 64'(bus.rsp_data2), ZERO_EN ? 64'd0 : 64'h0000_FFFF);

    // Randomized traffic; pending requests keep their payload until granted.
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < N; c++) begin
        if (!c_valid[c] && $urandom_range(0, 1) == 1)
          set_req(c, $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      end
      c_rsp_ready = $urandom_range(0, 3) != 0;
      reset = $urandom_range(0, 99) == 0;
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
